valve_sequencer: RTL and testbench



---
 rtl/valve_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_valve_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/valve_sequencer.sv
// Program sequencer for the microfluidic valve manifold: fetches 13-bit
// instructions from the shared memory and drives a registered valve bus.
module valve_sequencer #(
    parameter int NUM_VALVES = 8,
    parameter int MEM_DEPTH  = 101,
    parameter int ADDR_W     = 8,
    parameter int TICK_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [12:0]           instr,
    output logic [ADDR_W-1:0]     addr,
    output logic [NUM_VALVES-1:0] valves,
    output logic                  busy,
    output logic                  halted,
    output logic                  err
);

    // state    | meaning
    // IDLE     | memory being loaded; pc, valves, err held clear
    // FETCH    | latch instr at addr=pc into the instruction register
    // EXEC     | apply the latched opcode, pick the next pc
    // WAIT     | stall operand*TICK_DIV cycles, valves held
    // HALTED   | program ended; valves held until start drops
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALTED
    } state_t;

    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_OPEN  = 3'b010;
    localparam logic [2:0] OP_CLOSE = 3'b011;
    localparam logic [2:0] OP_WAIT  = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_RSV   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t                  state, state_d;
    logic [ADDR_W-1:0]       pc, pc_d;
    logic [NUM_VALVES-1:0]   valves_d;
    logic                    err_d;
    logic [12:0]             ir, ir_d;
    logic [9:0]              wait_cnt, wait_d;
    logic [TW-1:0]           tick, tick_d;

    logic [2:0]              opcode;
    logic [9:0]              operand;
    logic [NUM_VALVES-1:0]   mask;
    logic [ADDR_W-1:0]       pc_inc;
    logic [31:0]             pc_plus_wide;
    logic                    at_end;
    logic                    jump_ok;
    logic                    advance;

    assign opcode       = ir[12:10];
    assign operand      = ir[9:0];
    assign mask         = operand[NUM_VALVES-1:0];
    assign pc_inc       = pc + ADDR_W'(1);
    // Compared at 32 bits so the end check is exact for any ADDR_W.
    assign pc_plus_wide = 32'(pc) + 32'd1;
    assign at_end       = (pc_plus_wide == 32'(MEM_DEPTH));
    assign jump_ok      = (32'(operand) < 32'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            valves   <= '0;
            err      <= 1'b0;
            ir       <= '0;
            wait_cnt <= '0;
            tick     <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            valves   <= valves_d;
            err      <= err_d;
            ir       <= ir_d;
            wait_cnt <= wait_d;
            tick     <= tick_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        valves_d = valves;
        err_d    = err;
        ir_d     = ir;
        wait_d   = wait_cnt;
        tick_d   = tick;
        advance  = 1'b0;

        case (state)
            S_IDLE: begin
                pc_d     = '0;
                valves_d = '0;
                err_d    = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_SET: begin
                        valves_d = mask;
                        advance  = 1'b1;
                    end
                    OP_OPEN: begin
                        valves_d = valves | mask;
                        advance  = 1'b1;
                    end
                    OP_CLOSE: begin
                        valves_d = valves & ~mask;
                        advance  = 1'b1;
                    end
                    OP_WAIT: begin
                        if (operand == 10'd0) begin
                            advance = 1'b1;
                        end else begin
                            wait_d  = operand;
                            tick_d  = '0;
                            state_d = S_WAIT;
                        end
                    end
                    OP_JUMP: begin
                        if (jump_ok) begin
                            pc_d    = operand[ADDR_W-1:0];
                            state_d = S_FETCH;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_HALTED;
                        end
                    end
                    OP_RSV: begin
                        err_d   = 1'b1;
                        advance = 1'b1;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: advance = 1'b1;
                endcase
            end
            S_WAIT: begin
                if (tick == TICK_LAST) begin
                    tick_d = '0;
                    wait_d = wait_cnt - 10'd1;
                    if (wait_cnt == 10'd1) advance = 1'b1;
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            S_HALTED: ;
            default: state_d = S_IDLE;
        endcase

        // Falling off the end of the program is a fault, not a wrap.
        if (advance) begin
            if (at_end) begin
                err_d   = 1'b1;
                state_d = S_HALTED;
            end else begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
        end

        // Dropping start discards any in-flight instruction.
        if (!start) begin
            state_d  = S_IDLE;
            pc_d     = '0;
            valves_d = '0;
            err_d    = 1'b0;
            wait_d   = '0;
            tick_d   = '0;
        end
    end

    assign addr   = pc;
    assign busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
    assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_valve_sequencer.sv
// Directed bench for valve_sequencer: an instruction-level model expands each
// program into a per-cycle trace that is compared against the DUT outputs.
module tb_valve_sequencer;

    localparam int NV    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int TD    = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [12:0]   instr;
    logic [AW-1:0] addr;
    logic [NV-1:0] valves;
    logic          busy;
    logic          halted;
    logic          err;

    logic [12:0] prog [256];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] v;
        logic       b;
        logic       h;
        logic       e;
    } obs_t;

    obs_t exp_q[$];
    int   checks;
    int   failures;
    int   addr1_cnt;

    valve_sequencer #(
        .NUM_VALVES(NV),
        .MEM_DEPTH (DEPTH),
        .ADDR_W    (AW),
        .TICK_DIV  (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .instr (instr),
        .addr  (addr),
        .valves(valves),
        .busy  (busy),
        .halted(halted),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = prog[addr];

    function automatic logic [12:0] enc(input int op, input int opd);
        return {3'(op), 10'(opd)};
    endfunction

    task automatic load4(input logic [12:0] i0, input logic [12:0] i1,
                         input logic [12:0] i2, input logic [12:0] i3);
        for (int k = 0; k < 256; k++) prog[k] = 13'd0;
        prog[0] = i0;
        prog[1] = i1;
        prog[2] = i2;
        prog[3] = i3;
    endtask

    function automatic void push(input int pc, input logic [7:0] v,
                                 input logic b, input logic h, input logic e);
        exp_q.push_back({8'(pc), v, b, h, e});
    endfunction

    // Instruction-level interpreter: every instruction costs a fetch and an
    // execute cycle, a WAIT adds operand*TD cycles, effects land afterwards.
    task automatic build_model(input int ncyc);
        int          pc;
        logic [7:0]  v;
        logic        e;
        logic        hlt;
        logic        seq;
        logic [12:0] w;
        logic [2:0]  op;
        logic [9:0]  opd;
        exp_q.delete();
        pc = 0; v = 8'h00; e = 1'b0; hlt = 1'b0;
        while (exp_q.size() < ncyc) begin
            if (hlt) begin
                push(pc, v, 1'b0, 1'b1, e);
            end else begin
                w   = prog[pc];
                op  = w[12:10];
                opd = w[9:0];
                push(pc, v, 1'b1, 1'b0, e);
                push(pc, v, 1'b1, 1'b0, e);
                seq = 1'b1;
                case (op)
                    3'd1: v = opd[7:0];
                    3'd2: v = v | opd[7:0];
                    3'd3: v = v & ~opd[7:0];
                    3'd4: for (int n = 0; n < int'(opd) * TD; n++) push(pc, v, 1'b1, 1'b0, e);
                    3'd5: begin
                        seq = 1'b0;
                        if (int'(opd) < DEPTH) pc = int'(opd);
                        else begin e = 1'b1; hlt = 1'b1; end
                    end
                    3'd6: e = 1'b1;
                    3'd7: begin seq = 1'b0; hlt = 1'b1; end
                    default: ;
                endcase
                if (seq) begin
                    if (pc + 1 == DEPTH) begin e = 1'b1; hlt = 1'b1; end
                    else pc = pc + 1;
                end
            end
        end
        while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Raises start (DUT must be in IDLE) and compares ncyc cycles against the
    // model; returns just after the posedge following the last compared cycle.
    task automatic run_prog(input string nm, input int ncyc);
        obs_t act;
        obs_t ex;
        build_model(ncyc);
        addr1_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            act = {addr, valves, busy, halted, err};
            ex  = exp_q.pop_front();
            if (addr == 8'd1) addr1_cnt++;
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL %s cyc=%0d: got addr=%0d valves=%h busy=%b halted=%b err=%b expected addr=%0d valves=%h busy=%b halted=%b err=%b",
                         nm, i, act.a, act.v, act.b, act.h, act.e, ex.a, ex.v, ex.b, ex.h, ex.e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stop_run();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        addr1_cnt = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        load4(13'd0, 13'd0, 13'd0, 13'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_addr",   32'(addr),   32'd0);
        chk("reset_valves", 32'(valves), 32'h00);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_err",    32'(err),    32'd0);

        // SET / OPEN / CLOSE / HALT
        load4(enc(1, 'h0F), enc(2, 'h30), enc(3, 'h03), enc(7, 0));
        run_prog("t1_basic", 10);
        @(negedge clk);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_addr",   32'(addr),   32'd3);
        chk("t1_err",    32'(err),    32'd0);
        chk("t1_valves", 32'(valves), 32'h3C);
        stop_run();

        // WAIT 3 with TD=4: WAIT instruction occupies 2+12 cycles at addr 1
        load4(enc(1, 'h01), enc(4, 3), enc(1, 'h02), enc(7, 0));
        run_prog("t2_wait3", 22);
        chk("t2_wait_span", 32'(addr1_cnt), 32'd14);
        @(negedge clk);
        chk("t2_valves", 32'(valves), 32'h02);
        stop_run();

        load4(enc(1, 'h01), enc(4, 0), enc(1, 'h02), enc(7, 0));
        run_prog("t2_wait0", 10);
        chk("t2_wait0_span", 32'(addr1_cnt), 32'd2);
        stop_run();

        // JUMP loop and out-of-range JUMP
        load4(enc(2, 'h01), enc(5, 0), 13'd0, 13'd0);
        run_prog("t3_loop", 12);
        @(negedge clk);
        chk("t3_loop_busy", 32'(busy), 32'd1);
        chk("t3_loop_err",  32'(err),  32'd0);
        stop_run();

        load4(enc(2, 'h01), enc(5, 200), 13'd0, 13'd0);
        run_prog("t3_jump_oob", 6);
        @(negedge clk);
        chk("t3_oob_halted", 32'(halted), 32'd1);
        chk("t3_oob_err",    32'(err),    32'd1);
        chk("t3_oob_addr",   32'(addr),   32'd1);
        stop_run();

        // Running off the end, and the reserved opcode
        load4(13'd0, 13'd0, 13'd0, 13'd0);
        run_prog("t4_end", 10);
        @(negedge clk);
        chk("t4_end_halted", 32'(halted), 32'd1);
        chk("t4_end_err",    32'(err),    32'd1);
        chk("t4_end_addr",   32'(addr),   32'd3);
        stop_run();

        load4(enc(6, 0), enc(1, 'h05), enc(7, 0), 13'd0);
        run_prog("t4_rsv", 8);
        @(negedge clk);
        chk("t4_rsv_err",    32'(err),    32'd1);
        chk("t4_rsv_valves", 32'(valves), 32'h05);
        chk("t4_rsv_halted", 32'(halted), 32'd1);
        stop_run();

        // Drop start mid-WAIT, then re-run from address 0
        load4(enc(6, 0), enc(1, 'hAA), enc(4, 5), enc(7, 0));
        run_prog("t5_pre", 10);
        start = 1'b0;
        @(negedge clk);
        chk("t5_midwait_valves", 32'(valves), 32'hAA);
        @(negedge clk);
        chk("t5_idle_valves", 32'(valves), 32'h00);
        chk("t5_idle_busy",   32'(busy),   32'd0);
        chk("t5_idle_err",    32'(err),    32'd0);
        chk("t5_idle_addr",   32'(addr),   32'd0);
        run_prog("t5_rerun", 6);
        stop_run();

        // Reset pulse during EXEC of SET 0xFF
        load4(enc(1, 'hFF), enc(7, 0), 13'd0, 13'd0);
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_exec_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_valves", 32'(valves), 32'h00);
        chk("t6_rst_addr",   32'(addr),   32'd0);
        chk("t6_rst_busy",   32'(busy),   32'd0);
        chk("t6_rst_halted", 32'(halted), 32'd0);
        chk("t6_rst_err",    32'(err),    32'd0);
        run_prog("t6_after_rst", 6);
        stop_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
